midi_voice_allocator: RTL and testbench
=======================================

# midi_voice_allocator

Polyphonic note scheduler between `midi_framer` and a bank of `voice` instances. Consumes framed MIDI note-on/note-off/all-notes-off events and assigns each note to one of NUM_VOICES shared voices, driving per-voice note number and gate. When every voice is busy, it steals the least-recently-allocated voice. During a steal, the gate is held low long enough for the ADSR to retrigger. It replaces the fixed one-voice-per-note wiring, so a small voice bank can cover the full 0–127 note range.

## Interface

Parameters:
- NUM_VOICES, 8: number of managed voices (2–16).
- RETRIGGER_CYCLES, 1024: clk cycles the gate is held low on a steal or retrigger. Must exceed one sample-clock period (about 363 clk at 16 MHz / 44.1 kHz).
- OMNI, 1: 1 = accept all channels; 0 = accept only CHANNEL.
- CHANNEL, 0: MIDI channel 0–15, used when OMNI=0.

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  synchronous, active-high reset.
- midi_event_valid  in  1  framer event available; held until acked.
- midi_command  in  8  status byte.
- midi_parameter_1  in  8  note number / controller number.
- midi_parameter_2  in  8  velocity / controller value.
- midi_data_ack  out  1  one-cycle pulse; event consumed.
- voice_gate  out  NUM_VOICES  per-voice gate, bit v = voice v.
- voice_note  out  7*NUM_VOICES  per-voice note; bits [7v+6:7v] = voice v.
- busy  out  1  high in any state other than IDLE.

## Operation

- State machine: IDLE, DECIDE, RETRIG, ACK, WAIT.
- IDLE: when midi_event_valid=1, register command and both parameters, then go to DECIDE.
- DECIDE classifies the registered event:
  - Channel mismatch (OMNI=0 and command[3:0]≠CHANNEL), or an unhandled command: no change; go to ACK.
  - Note-off: 0x8n, or 0x9n with velocity 0. Clear the gate of every voice with gate=1 and a matching note. Go to ACK.
  - All-notes-off: 0xBn with param1=123. Clear all gates. Go to ACK.
  - Note-on (0x9n, velocity>0) follows this priority:
    - (a) A voice with gate=1 and the same note is the target. Go to RETRIG.
    - (b) Otherwise, the lowest-index voice with gate=0 is the target. Load the note, set the gate, go to ACK.
    - (c) Otherwise, steal: the target is the voice with the maximum age, ties broken by lowest index. Go to RETRIG.
- RETRIG:
  - Target gate forced to 0 and a counter loaded with RETRIGGER_CYCLES-1.
  - On the cycle the counter reaches 0: load the note, set gate=1, go to ACK.
- ACK: midi_data_ack=1 for exactly one cycle, then go to WAIT.
- WAIT: stay until midi_event_valid=0, then go to IDLE. This prevents processing one event twice.
- Age tracking (per voice, 8-bit, saturating at 255), on every note-on allocation ((a), (b) or (c)):
  - Target age cleared to 0.
  - Every other voice's age increments, saturating.
- Voice notes retain their last value after gate clear, so release tails keep their pitch.
- Note numbers use param1[6:0]; param1[7] is ignored.

## Timing

- Reset: voice_gate=0, voice_note=0, all ages=0, midi_data_ack=0, busy=0, state=IDLE, counter=0.
- Reset is honoured in every state, including mid-RETRIG: the steal is abandoned and no ack is issued.
- Event latency for a non-steal event:
  - valid sampled in IDLE at cycle t.
  - Gate/note updated and visible at t+2.
  - midi_data_ack high at t+2, for one cycle.
- Steal/retrigger latency:
  - Target gate low from t+2 through t+1+RETRIGGER_CYCLES.
  - New note and gate=1 visible at t+2+RETRIGGER_CYCLES, with ack in that same cycle.
- While busy, no new events are accepted. The framer stalls because ack is withheld.
- Simultaneous free voices: the lowest index always wins.
- Duplicate note-off for an unheld note: no change; still acked.
- Age wraps never; saturation at 255 is required.

## Test plan

- **Reset and single note:** rst high for 2 cycles, then note-on 0x90/60/100 → voice_gate=8'b00000001, voice 0 note=60, one ack pulse 2 cycles after valid; busy=0 after WAIT.
- **Fill the bank:** note-ons 60..67, then note-off 0x80/62 → gates 0xFF, then 0xFB. Next note-on 70 lands in voice 2.
- **Steal:** 8 notes held, then note-on 72 → voice 0 (oldest) gate low for exactly RETRIGGER_CYCLES cycles, then note=72 with gate=1. Ages: voice 0 = 0.
- **Velocity-zero and all-notes-off:** 0x90/60/0 releases note 60; 0xB0/123/0 clears all gates. Each is acked once.
- **Channel filter:** OMNI=0, CHANNEL=2. 0x91/60/100 → no gate change, but acked. 0x92/60/100 → voice 0 gated.
- **Handshake/reset edge:** hold valid high for 5 cycles after ack → exactly one allocation. Assert rst midway through RETRIG → all outputs return to reset values next cycle, and no ack.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: assigns framed MIDI note events to a bank of shared
// voices, stealing the least-recently-allocated voice when the bank is full
// and holding its gate low long enough for the envelope to retrigger.
module midi_voice_allocator #(
  parameter int NUM_VOICES       = 8,
  parameter int RETRIGGER_CYCLES = 1024,
  parameter int OMNI             = 1,
  parameter int CHANNEL          = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      midi_event_valid,
  input  logic [7:0]                midi_command,
  input  logic [7:0]                midi_parameter_1,
  input  logic [7:0]                midi_parameter_2,
  output logic                      midi_data_ack,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [7*NUM_VOICES-1:0]   voice_note,
  output logic                      busy
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int CW = (RETRIGGER_CYCLES > 1) ? $clog2(RETRIGGER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RETRIGGER_CYCLES - 1);
  localparam logic [3:0] CH = 4'(CHANNEL);

  typedef enum logic [2:0] {IDLE, DECIDE, RETRIG, ACK, WAIT} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cmd_q, p1_q, p2_q;
  logic [NUM_VOICES-1:0]     gate_q, gate_d;
  logic [7*NUM_VOICES-1:0]   note_q, note_d;
  logic [8*NUM_VOICES-1:0]   age_q, age_d;
  logic [VW-1:0]             tgt_q, tgt_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic                      chan_ok, is_on, is_off, is_ano;
  logic [6:0]                ev_note;
  logic                      match_found, free_found;
  logic [VW-1:0]             match_idx, free_idx, old_idx, alloc_idx;
  logic [7:0]                old_age;

  function automatic logic [7:0] sat_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  assign chan_ok = (OMNI != 0) || (cmd_q[3:0] == CH);
  assign is_on   = (cmd_q[7:4] == 4'h9) && (p2_q != 8'd0);
  assign is_off  = (cmd_q[7:4] == 4'h8) || ((cmd_q[7:4] == 4'h9) && (p2_q == 8'd0));
  assign is_ano  = (cmd_q[7:4] == 4'hB) && (p1_q == 8'd123);
  assign ev_note = p1_q[6:0];

  // Locate a held voice with the same note, the lowest free voice and the oldest voice.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate_q[v] && (note_q[7*v +: 7] == ev_note)) begin
        match_found = 1'b1;
        match_idx   = VW'(v);
      end
      if (!gate_q[v]) begin
        free_found = 1'b1;
        free_idx   = VW'(v);
      end
    end
    old_idx = '0;
    old_age = age_q[7:0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[8*v +: 8] > old_age) begin
        old_age = age_q[8*v +: 8];
        old_idx = VW'(v);
      end
    end
    alloc_idx = match_found ? match_idx : (free_found ? free_idx : old_idx);
  end

  // Next-state, voice updates and handshake outputs.
  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    note_d        = note_q;
    age_d         = age_q;
    tgt_d         = tgt_q;
    cnt_d         = cnt_q;
    midi_data_ack = 1'b0;
    case (state_q)
      IDLE: if (midi_event_valid) state_d = DECIDE;
      DECIDE: begin
        state_d = ACK;
        if (chan_ok && is_on) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            age_d[8*v +: 8] = (VW'(v) == alloc_idx) ? 8'd0 : sat_inc(age_q[8*v +: 8]);
          end
          tgt_d = alloc_idx;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (VW'(v) == alloc_idx) begin
              if (!match_found && free_found) begin
                gate_d[v]        = 1'b1;
                note_d[7*v +: 7] = ev_note;
              end else begin
                gate_d[v] = 1'b0;
              end
            end
          end
          if (match_found || !free_found) begin
            cnt_d   = CNT_LOAD;
            state_d = RETRIG;
          end
        end else if (chan_ok && is_off) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v] && (note_q[7*v +: 7] == ev_note)) gate_d[v] = 1'b0;
          end
        end else if (chan_ok && is_ano) begin
          gate_d = '0;
        end
      end
      RETRIG: begin
        if (cnt_q == '0) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (VW'(v) == tgt_q) begin
              gate_d[v]        = 1'b1;
              note_d[7*v +: 7] = ev_note;
            end
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        midi_data_ack = 1'b1;
        state_d       = WAIT;
      end
      WAIT: if (!midi_event_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, event capture and voice registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      gate_q  <= '0;
      note_q  <= '0;
      age_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      note_q  <= note_d;
      age_q   <= age_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && midi_event_valid) begin
        cmd_q <= midi_command;
        p1_q  <= midi_parameter_1;
        p2_q  <= midi_parameter_2;
      end
    end
  end

  assign voice_gate = gate_q;
  assign voice_note = note_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator: an omni instance and a
// channel-2-only instance share the same event stream.
module tb_midi_voice_allocator;

  localparam int NV = 8;
  localparam int RC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [7:0]      cmd, par1, par2;
  logic            ack0, ack1, busy0, busy1;
  logic [NV-1:0]   gate0, gate1;
  logic [7*NV-1:0] note0, note1;

  int passed = 0;
  int total  = 0;

  midi_voice_allocator #(.NUM_VOICES(NV), .RETRIGGER_CYCLES(RC), .OMNI(1), .CHANNEL(0)) dut0 (
    .clk(clk), .rst(rst), .midi_event_valid(valid), .midi_command(cmd),
    .midi_parameter_1(par1), .midi_parameter_2(par2), .midi_data_ack(ack0),
    .voice_gate(gate0), .voice_note(note0), .busy(busy0));

  midi_voice_allocator #(.NUM_VOICES(NV), .RETRIGGER_CYCLES(RC), .OMNI(0), .CHANNEL(2)) dut1 (
    .clk(clk), .rst(rst), .midi_event_valid(valid), .midi_command(cmd),
    .midi_parameter_1(par1), .midi_parameter_2(par2), .midi_data_ack(ack1),
    .voice_gate(gate1), .voice_note(note1), .busy(busy1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Presents one event, waits (bounded) for dut0's ack, then releases valid.
  task automatic send(input logic [7:0] c, input logic [7:0] p1, input logic [7:0] p2,
                      input int mon, output int lat, output int acks,
                      output int acks1, output int low);
    cmd = c; par1 = p1; par2 = p2; valid = 1'b1;
    lat = -1; acks = 0; acks1 = 0; low = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (!gate0[mon]) low++;
      if (ack1) acks1++;
      if (ack0) begin
        acks++;
        lat = k;
        break;
      end
    end
    valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      acks  += int'(ack0);
      acks1 += int'(ack1);
    end
  endtask

  initial begin
    int lat, acks, acks1, low, extra;
    logic [7*NV-1:0] expn;

    rst = 1'b1; valid = 1'b0; cmd = '0; par1 = '0; par2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gate", 64'(gate0), 64'h0);
    chk("reset_note", 64'(note0), 64'h0);
    chk("reset_ack", 64'(ack0), 64'h0);
    chk("reset_busy", 64'(busy0), 64'h0);
    rst = 1'b0;

    // single note
    send(8'h90, 8'd60, 8'd100, 0, lat, acks, acks1, low);
    chk("single_lat", 64'(lat), 64'd2);
    chk("single_acks", 64'(acks), 64'd1);
    chk("single_gate", 64'(gate0), 64'h01);
    chk("single_note", 64'(note0[6:0]), 64'd60);
    chk("single_busy", 64'(busy0), 64'h0);

    // fill the bank
    for (int i = 61; i <= 67; i++) send(8'h90, 8'(i), 8'd100, 0, lat, acks, acks1, low);
    expn = '0;
    for (int i = 0; i < NV; i++) expn[7*i +: 7] = 7'(60 + i);
    chk("fill_gate", 64'(gate0), 64'hFF);
    chk("fill_notes", 64'(note0), 64'(expn));
    chk("ch_filter_ignores_ch0", 64'(gate1), 64'h0);

    send(8'h80, 8'd62, 8'd64, 0, lat, acks, acks1, low);
    chk("noteoff_gate", 64'(gate0), 64'hFB);
    chk("noteoff_acks", 64'(acks), 64'd1);

    send(8'h90, 8'd70, 8'd100, 0, lat, acks, acks1, low);
    chk("refill_gate", 64'(gate0), 64'hFF);
    chk("refill_v2_note", 64'(note0[20:14]), 64'd70);

    // steal the oldest voice (voice 0)
    send(8'h90, 8'd72, 8'd100, 0, lat, acks, acks1, low);
    chk("steal_low_cycles", 64'(low), 64'(RC));
    chk("steal_lat", 64'(lat), 64'(RC + 2));
    chk("steal_acks", 64'(acks), 64'd1);
    chk("steal_v0_note", 64'(note0[6:0]), 64'd72);
    chk("steal_gate", 64'(gate0), 64'hFF);

    // voice 0 age was cleared, so voice 1 is now oldest
    send(8'h90, 8'd73, 8'd100, 1, lat, acks, acks1, low);
    chk("steal2_lat", 64'(lat), 64'(RC + 2));
    chk("steal2_v1_note", 64'(note0[13:7]), 64'd73);
    chk("steal2_v0_kept", 64'(note0[6:0]), 64'd72);

    // retrigger of a held note
    send(8'h90, 8'd72, 8'd90, 0, lat, acks, acks1, low);
    chk("retrig_low_cycles", 64'(low), 64'(RC));
    chk("retrig_lat", 64'(lat), 64'(RC + 2));
    chk("retrig_gate", 64'(gate0), 64'hFF);

    // velocity-zero note-on releases
    send(8'h90, 8'd72, 8'd0, 0, lat, acks, acks1, low);
    chk("vel0_gate", 64'(gate0), 64'hFE);
    chk("vel0_acks", 64'(acks), 64'd1);

    send(8'h80, 8'd72, 8'd0, 0, lat, acks, acks1, low);
    chk("dup_off_gate", 64'(gate0), 64'hFE);
    chk("dup_off_lat", 64'(lat), 64'd2);

    // param1 bit 7 ignored; lands in free voice 0
    send(8'h90, 8'h85, 8'd100, 0, lat, acks, acks1, low);
    chk("p1msb_note", 64'(note0[6:0]), 64'd5);
    chk("p1msb_gate", 64'(gate0), 64'hFF);

    // all-notes-off clears gates but notes persist
    send(8'hB0, 8'd123, 8'd0, 0, lat, acks, acks1, low);
    chk("ano_gate", 64'(gate0), 64'h00);
    chk("ano_note_kept", 64'(note0[6:0]), 64'd5);
    chk("ano_acks", 64'(acks), 64'd1);

    // unhandled controller: acked, no change
    send(8'hB0, 8'd7, 8'd100, 0, lat, acks, acks1, low);
    chk("cc_gate", 64'(gate0), 64'h00);
    chk("cc_acks", 64'(acks), 64'd1);

    // valid held after ack: only one allocation
    cmd = 8'h90; par1 = 8'd50; par2 = 8'd100; valid = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (ack0) begin
        lat = k;
        break;
      end
    end
    chk("hold_lat", 64'(lat), 64'd2);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      extra += int'(ack0);
    end
    chk("hold_extra_acks", 64'(extra), 64'd0);
    chk("hold_busy", 64'(busy0), 64'h1);
    chk("hold_gate", 64'(gate0), 64'h01);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_idle", 64'(busy0), 64'h0);

    // reset in the middle of a retrigger
    cmd = 8'h90; par1 = 8'd50; par2 = 8'd100; valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midretrig_gate_low", 64'(gate0[0]), 64'h0);
    chk("midretrig_busy", 64'(busy0), 64'h1);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_gate", 64'(gate0), 64'h0);
    chk("rst_note", 64'(note0), 64'h0);
    chk("rst_ack", 64'(ack0), 64'h0);
    chk("rst_busy", 64'(busy0), 64'h0);
    rst = 1'b0;
    extra = 0;
    repeat (RC + 8) begin
      @(posedge clk); #1;
      extra += int'(ack0);
    end
    chk("rst_no_ack", 64'(extra), 64'd0);

    // channel filter on the channel-2 instance
    send(8'h91, 8'd60, 8'd100, 0, lat, acks, acks1, low);
    chk("ch1_gate", 64'(gate1), 64'h00);
    chk("ch1_acks", 64'(acks1), 64'd1);
    send(8'h92, 8'd60, 8'd100, 0, lat, acks, acks1, low);
    chk("ch2_gate", 64'(gate1), 64'h01);
    chk("ch2_note", 64'(note1[6:0]), 64'd60);
    chk("ch2_acks", 64'(acks1), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
